// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_scheduler
// Description : Write-back scheduler and pending-write scoreboard for the
//               32x32 register file. Round-robin arbitration of NREQ
//               write-back sources onto one registered write port, plus
//               RAW/WAW stall generation for the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_scheduler #(
    parameter int NREQ = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     wb_valid,
    input  logic [5*NREQ-1:0]   wb_addr,
    input  logic [32*NREQ-1:0]  wb_data,
    output logic [NREQ-1:0]     wb_ready,
    output logic                rf_wen,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    input  logic                iss_valid,
    input  logic [4:0]          iss_dest,
    input  logic [4:0]          iss_src1,
    input  logic [4:0]          iss_src2,
    output logic                iss_stall
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0] c_nreq = (PW+1)'(NREQ);

    logic [4:0]     w_addr_arr [NREQ];
    logic [31:0]    w_data_arr [NREQ];
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_gidx;
    logic [PW-1:0]  w_ptr_next;
    logic [PW:0]    w_sum;
    logic           w_found;
    logic [4:0]     w_gaddr;
    logic [31:0]    w_gdata;
    logic [31:0]    r_pend;
    logic [31:0]    w_pend_next;
    logic           w_hit1;
    logic           w_hit2;
    logic           w_hitd;
    logic           w_set;

    // Split the flat request buses into per-requester fields
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = wb_addr[5*gi +: 5];
            assign w_data_arr[gi] = wb_data[32*gi +: 32];
        end
    endgenerate

    // Round-robin search starting at the pointer, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            if (!w_found && wb_valid[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[PW-1:0];
            end
        end
    end

    assign w_ptr_next = (w_gidx == PW'(NREQ-1)) ? '0 : (w_gidx + PW'(1));
    assign w_gaddr    = w_addr_arr[w_gidx];
    assign w_gdata    = w_data_arr[w_gidx];

    // One-hot grant; suppressed while reset is held so no handshake completes
    always_comb begin
        wb_ready = '0;
        if (w_found && !reset) begin
            wb_ready[w_gidx] = 1'b1;
        end
    end

    // Registered write port and arbitration pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
            r_ptr    <= '0;
        end else begin
            rf_wen <= w_found && (w_gaddr != 5'd0);
            if (w_found) begin
                rf_waddr <= w_gaddr;
                rf_wdata <= w_gdata;
                r_ptr    <= w_ptr_next;
            end
        end
    end

    // Hazard detection against the current scoreboard; r0 never hazards
    assign w_hit1    = (iss_src1 != 5'd0) && r_pend[iss_src1];
    assign w_hit2    = (iss_src2 != 5'd0) && r_pend[iss_src2];
    assign w_hitd    = (iss_dest != 5'd0) && r_pend[iss_dest];
    assign iss_stall = iss_valid && (w_hit1 || w_hit2 || w_hitd);
    assign w_set     = iss_valid && !iss_stall && (iss_dest != 5'd0);

    // Next scoreboard: clear on write-back, set on accepted issue
    always_comb begin
        w_pend_next = r_pend;
        if (rf_wen) begin
            w_pend_next[rf_waddr] = 1'b0;
        end
        if (w_set) begin
            w_pend_next[iss_dest] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 32'd0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_scheduler
// Description : Self-checking bench for rf_wb_scheduler: directed vectors
//               with literal expectations plus a per-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_scheduler;

    localparam int NREQ = 3;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     wb_valid;
    logic [5*NREQ-1:0]   wb_addr;
    logic [32*NREQ-1:0]  wb_data;
    logic [NREQ-1:0]     wb_ready;
    logic                rf_wen;
    logic [4:0]          rf_waddr;
    logic [31:0]         rf_wdata;
    logic                iss_valid;
    logic [4:0]          iss_dest;
    logic [4:0]          iss_src1;
    logic [4:0]          iss_src2;
    logic                iss_stall;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic        m_known = 1'b0;
    int          m_ptr   = 0;
    logic [31:0] m_pend  = '0;
    logic        m_wen   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    int rr1 [8] = '{0, 1, 2, 0, 1, 2, 0, 1};
    int rr2 [4] = '{2, 0, 2, 0};

    rf_wb_scheduler #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .iss_valid (iss_valid),
        .iss_dest  (iss_dest),
        .iss_src1  (iss_src1),
        .iss_src2  (iss_src2),
        .iss_stall (iss_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First valid requester scanning ptr, ptr+1, ... modulo NREQ; -1 if none
    function automatic int arb(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [4:0] req_addr(input int i);
        return wb_addr[5*i +: 5];
    endfunction

    function automatic logic [31:0] req_data(input int i);
        return wb_data[32*i +: 32];
    endfunction

    function automatic logic pend_hit(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r];
    endfunction

    function automatic logic model_stall();
        return iss_valid && (pend_hit(iss_src1) || pend_hit(iss_src2) || pend_hit(iss_dest));
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int g;
        r = '0;
        g = arb(m_ptr, wb_valid);
        if (!reset && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_pend_next();
        logic [31:0] p;
        p = m_pend;
        if (m_wen) p[m_waddr] = 1'b0;
        if (iss_valid && !model_stall() && iss_dest != 5'd0) p[iss_dest] = 1'b1;
        return p;
    endfunction

    // Model advances on each rising edge from the inputs of the closing cycle
    always @(posedge clk) begin
        if (reset) begin
            m_known <= 1'b1;
            m_ptr   <= 0;
            m_pend  <= '0;
            m_wen   <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
        end else begin
            m_pend <= model_pend_next();
            if (arb(m_ptr, wb_valid) >= 0) begin
                m_ptr   <= (arb(m_ptr, wb_valid) + 1) % NREQ;
                m_wen   <= (req_addr(arb(m_ptr, wb_valid)) != 5'd0);
                m_waddr <= req_addr(arb(m_ptr, wb_valid));
                m_wdata <= req_data(arb(m_ptr, wb_valid));
            end else begin
                m_wen <= 1'b0;
            end
        end
    end

    // Per-cycle comparison, sampled mid-way between edges
    always begin
        @(negedge clk);
        #3;
        if (m_known) begin
            chk("m_wb_ready", wb_ready, model_ready());
            chk("m_iss_stall", iss_stall, model_stall());
            chk("m_rf_wen", rf_wen, m_wen);
            chk("m_rf_waddr", rf_waddr, m_waddr);
            chk("m_rf_wdata", rf_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        wb_valid  = '0;
        wb_addr   = '0;
        wb_data   = '0;
        iss_valid = 1'b0;
        iss_dest  = '0;
        iss_src1  = '0;
        iss_src2  = '0;

        // Reset held two cycles, then idle
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_stall", iss_stall, 1'b0);
        chk("rst_ready", wb_ready, 3'b000);

        // Single write from the ALU
        tick();
        wb_valid = 3'b001;
        wb_addr[0 +: 5] = 5'd5;
        wb_data[0 +: 32] = 32'hDEADBEEF;
        settle();
        chk("single_ready", wb_ready, 3'b001);
        tick();
        wb_valid = 3'b000;
        settle();
        chk("single_wen", rf_wen, 1'b1);
        chk("single_waddr", rf_waddr, 5'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        settle();
        chk("single_wen_off", rf_wen, 1'b0);

        // Round-robin with all three requesters, pointer restarted at 0
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wb_valid = 3'b111;
        wb_addr[0 +: 5] = 5'd1;
        wb_addr[5 +: 5] = 5'd2;
        wb_addr[10 +: 5] = 5'd3;
        wb_data[0 +: 32] = 32'h0000_0011;
        wb_data[32 +: 32] = 32'h0000_0022;
        wb_data[64 +: 32] = 32'h0000_0033;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("rr_grant", wb_ready, 64'd1 << rr1[k]);
            tick();
        end
        wb_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_drop_grant", wb_ready, 64'd1 << rr2[k]);
            tick();
        end
        wb_valid = 3'b000;

        // RAW: dest 7 issued, then src1=7 stalls until write-back lands
        iss_valid = 1'b1;
        iss_dest  = 5'd7;
        settle();
        chk("raw_issue", iss_stall, 1'b0);
        tick();
        iss_dest = 5'd0;
        iss_src1 = 5'd7;
        settle();
        chk("raw_stall", iss_stall, 1'b1);
        tick();
        wb_valid = 3'b010;
        wb_addr[5 +: 5] = 5'd7;
        wb_data[32 +: 32] = 32'h0000_0777;
        settle();
        chk("raw_grant", wb_ready, 3'b010);
        chk("raw_stall_u", iss_stall, 1'b1);
        tick();
        wb_valid = 3'b000;
        settle();
        chk("raw_wen", rf_wen, 1'b1);
        chk("raw_waddr", rf_waddr, 5'd7);
        chk("raw_stall_u1", iss_stall, 1'b1);
        tick();
        settle();
        chk("raw_release", iss_stall, 1'b0);

        // WAW on r9 and r0 handling
        tick();
        iss_src1 = 5'd0;
        iss_dest = 5'd9;
        settle();
        chk("waw_issue", iss_stall, 1'b0);
        tick();
        settle();
        chk("waw_stall", iss_stall, 1'b1);
        tick();
        iss_dest = 5'd0;
        settle();
        chk("r0_issue", iss_stall, 1'b0);
        tick();
        iss_valid = 1'b0;
        wb_valid = 3'b100;
        wb_addr[10 +: 5] = 5'd0;
        wb_data[64 +: 32] = 32'h0000_1234;
        settle();
        chk("r0_ready", wb_ready, 3'b100);
        tick();
        wb_valid = 3'b000;
        settle();
        chk("r0_wen", rf_wen, 1'b0);

        // Reset arriving with r3 pending and a write to r3 requested
        tick();
        iss_valid = 1'b1;
        iss_dest  = 5'd3;
        settle();
        chk("mid_issue", iss_stall, 1'b0);
        tick();
        iss_valid = 1'b0;
        iss_dest  = 5'd0;
        wb_valid  = 3'b001;
        wb_addr[0 +: 5] = 5'd3;
        wb_data[0 +: 32] = 32'h0000_0333;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        wb_valid  = 3'b000;
        iss_valid = 1'b1;
        iss_src1  = 5'd3;
        settle();
        chk("mid_wen", rf_wen, 1'b0);
        chk("mid_src3", iss_stall, 1'b0);
        tick();
        iss_src1 = 5'd9;
        settle();
        chk("mid_src9", iss_stall, 1'b0);
        tick();
        iss_valid = 1'b0;
        iss_src1  = 5'd0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Write-back scheduler and scoreboard for the 32x32 register file (one write port, two read ports) in the advanced CPU.
- Arbitrates the single write port among NREQ write-back sources (ALU, load unit, multiply/divide unit) using round-robin.
- Drives the write port from registers.
- Tracks a per-register pending-write scoreboard and raises a stall to the issue stage on RAW and WAW hazards.

Parameters:
- NREQ, 3, number of write-back requesters; index 0 = ALU, 1 = load, 2 = MDU (valid range 2..8).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  NREQ  per-requester write request.
- wb_addr  input  5*NREQ  destination register; requester i uses bits [5i+4:5i].
- wb_data  input  32*NREQ  write data; requester i uses bits [32i+31:32i].
- wb_ready  output  NREQ  one-hot grant; the request completes in a cycle where valid and ready are both high.
- rf_wen  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  32  register-file write data (registered).
- iss_valid  input  1  issue stage presents an instruction.
- iss_dest  input  5  destination register of the issuing instruction; 0 means no write.
- iss_src1  input  5  source register 1.
- iss_src2  input  5  source register 2.
- iss_stall  output  1  hold the issuing instruction (combinational).

Behaviour:
- Reset, sampled at posedge clk:
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - Pending scoreboard cleared to all 0.
  - Round-robin pointer = 0.
  - wb_ready=0 in the cycle after reset is asserted.
  - Writes in flight when reset arrives are dropped and not replayed.
- Handshake rules:
  - A requester holds wb_valid, wb_addr and wb_data stable until it sees wb_ready.
  - wb_ready never asserts for a requester whose wb_valid is low.
  - At most one wb_ready bit is high per cycle.
- Arbitration:
  - wb_ready is combinational from wb_valid and the pointer.
  - Search order is ptr, ptr+1, ..., wrapping modulo NREQ.
  - The first valid requester in that order is granted.
  - On a grant to index g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
  - A requester held off by others is granted within NREQ-1 cycles.
- Write port, one-cycle latency:
  - A grant in cycle t gives rf_wen=1, rf_waddr=addr and rf_wdata=data in cycle t+1.
  - The register file captures the value at the end of cycle t+1; it is readable in cycle t+2.
  - With no grant in cycle t, rf_wen=0 in t+1. rf_waddr and rf_wdata hold their last values.
  - A granted request with addr 0 is consumed (ready high) but produces rf_wen=0.
- Scoreboard (32 bits, bit 0 tied to 0):
  - Set: iss_valid && !iss_stall && iss_dest!=0 sets pend[iss_dest] at the edge.
  - Clear: rf_wen=1 clears pend[rf_waddr] at the edge.
  - A write-back to a non-pending register is legal; its pend bit stays 0.
- Stall:
  - iss_stall = iss_valid && (hit(iss_src1) || hit(iss_src2) || hit(iss_dest)), where hit(r) = (r!=0) && pend[r].
  - iss_stall is forced to 0 when iss_valid=0.
  - Stalling on dest (WAW) guarantees at most one outstanding write per register, so one bit per register suffices.
  - The stall uses the pend value before the edge. An instruction whose source clears at edge E is released in the cycle after E, which is when the register file holds the new data.
- Simultaneous events:
  - Set and clear of the same register cannot coincide, because a set requires !pend[dest].
  - Set and clear of different registers in the same cycle both take effect.
  - Reset has priority over all set, clear and grant activity.

Test Plan:
- Reset then idle: assert reset 2 cycles, all wb_valid=0, iss_valid=0 -> rf_wen=0, rf_waddr=0, rf_wdata=0, iss_stall=0, wb_ready=000.
- Single write: wb_valid=001, addr=5, data=0xDEADBEEF in cycle t -> wb_ready=001 in t; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in t+1; rf_wen=0 in t+2.
- Round-robin fairness: all three requesters valid continuously with distinct addrs 1, 2, 3 -> grants 0, 1, 2, 0, 1, 2 on successive cycles. Drop requester 1 after its first grant -> sequence continues 2, 0, 2, 0.
- RAW stall:
  - Issue dest=7 in cycle t -> pend[7]=1.
  - Next, issue src1=7 -> iss_stall=1.
  - Requester 1 is granted addr 7 at cycle u -> rf_wen=1 in u+1 with iss_stall still 1; iss_stall=0 in u+2.
- WAW and r0:
  - With pend[9]=1, iss_dest=9 (srcs 0) -> iss_stall=1.
  - iss_dest=0, src1=0, src2=0 -> iss_stall=0 and no pend bit is set.
  - wb request to addr 0 -> wb_ready=1 and rf_wen stays 0.
- Reset mid-operation:
  - pend[3]=1, grant in flight to addr 3, reset asserted in the same cycle -> next cycle rf_wen=0, pend all 0.
  - Issue src1=3 -> iss_stall=0.
